uart_rx_poller: RTL
===================

// Module: uart_rx_poller
// PURPOSE
//  Wishbone initiator for the UART device command protocol (16-byte map: data half at byte offset 0, command half at byte offset 8).
//  Periodically runs GETBUFFERUSAGE on the rx side, then reads the pending bytes from the data half.
//  Delivers each byte on a valid/ready stream to an on-chip consumer (boot loader, console sink) with no CPU involvement.
//  Owns the UART device exclusively; no other master may issue commands while en_i is high.
// PARAMETERS
//  ARCHBITSZ  16    data-bus width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8)
//  BASEADDR   0     device word address, ADDRBITSZ wide, aligned to 128/ARCHBITSZ words
//  POLLCYCLES 1000  idle cycles between polls when usage==0 or status is bad; >=1
// PORTS
//  clk_i      in   1              clock
//  rst_i      in   1              synchronous active-high reset
//  en_i       in   1              polling enable, sampled only in IDLE
//  wb_cyc_o   out  1              bus cycle
//  wb_stb_o   out  1              request strobe
//  wb_we_o    out  1              1=write
//  wb_addr_o  out  ADDRBITSZ      word address
//  wb_sel_o   out  ARCHBITSZ/8    byte selects, always all-ones when stb
//  wb_dat_o   out  ARCHBITSZ      write data
//  wb_bsy_i   in   1              slave busy; request accepted when stb_o && !bsy_i
//  wb_ack_i   in   1              transaction completion
//  wb_dat_i   in   ARCHBITSZ      read data, valid with ack
//  rx_stb_o   out  1              byte valid
//  rx_dat_o   out  8              received byte
//  rx_rdy_i   in   1              consumer ready; transfer = rx_stb_o && rx_rdy_i
//  err_o      out  1              one-cycle pulse on bad GETBUF status
// BEHAVIOUR
//  Reset (rst_i=1 at edge): all outputs 0, state IDLE, usage/poll counters 0. Applied mid-transaction, the bus request is dropped the next cycle and any late ack is ignored.
//  Addresses: CMD = BASEADDR + 64/ARCHBITSZ; DAT = BASEADDR. Command word = {arg[ARCHBITSZ-3:0], cmd[1:0]}; DEVRDY=0, GETBUF=1.
//  Bus op (one outstanding, outputs registered):
//   - Raise cyc+stb with we/addr/dat.
//   - Hold stb until the cycle with !wb_bsy_i, then drop stb; keep cyc high.
//   - On wb_ack_i drop cyc the same edge and capture wb_dat_i.
//   - Ack is accepted in the accept cycle too. No timeout.
//  FSM (each *_W / *_R is one bus op, advancing on ack):
//   IDLE:     en_i -> RDY0_W; else stay.
//   RDY0_W:   write CMD=0 (forces device ready).
//   GBUF_W:   write CMD={0,1}; arg bit0=0 selects rx usage.
//   GBUF_R:   read CMD -> status.
//             status[1:0]==1: usage<=status[ARCHBITSZ-1:2].
//             Else err_o pulse and usage<=0.
//   RDY1_W:   write CMD=0, required before data reads. usage==0 -> WAIT; else DAT_R.
//   DAT_R:    read DAT; rx_dat_o<=wb_dat_i[7:0], rx_stb_o<=1 on ack -> OUT.
//   OUT:      hold rx_stb_o/rx_dat_o stable until rx_rdy_i.
//             On transfer: rx_stb_o<=0, usage<=usage-1.
//             Next: DAT_R if usage-1!=0, else IDLE (immediate repoll).
//   WAIT:     count POLLCYCLES cycles, then IDLE.
//  Latency: with a slave giving ack 2 cycles after accept, first byte rx_stb_o at cycle <=20 after en_i in IDLE.
//  en_i low mid-sequence does not abort; the block returns to IDLE at the next IDLE entry.
//  Usage counter ARCHBITSZ-2 wide, never decremented below 0. Byte reads = reported usage exactly, no re-poll in between.
//  rx_stb_o held with rx_rdy_i low indefinitely: no bus activity (cyc_o=0).
// TESTING
//  1. Slave model reports usage=2 with bytes 0x41,0x42, rx_rdy_i=1.
//     -> Bus sequence W CMD 0, W CMD 1, R CMD (0x0009), W CMD 0, R DAT, R DAT.
//     -> Stream 0x41 then 0x42, then repoll.
//  2. usage=0 -> after RDY1_W: cyc_o=0 for exactly POLLCYCLES cycles, then RDY0_W begins. No rx_stb_o.
//  3. Status 0x0002 (bad) -> err_o high exactly one cycle, no data reads, WAIT entered.
//  4. wb_bsy_i high 5 cycles on GBUF_W -> stb_o held 6 cycles, addr/dat stable (CMD, 0x0001); single ack consumed.
//  5. rx_rdy_i low 10 cycles in OUT -> rx_stb_o/rx_dat_o stable, cyc_o=0; one transfer when ready rises.
//  6. rst_i pulsed during DAT_R stb -> next cycle all outputs 0; stray ack ignored; with en_i=1, next op is W CMD 0.

Source files
------------

// File: rtl/uart_rx_poller.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_poller
//  Purpose  : Wishbone initiator that owns a UART device and drains its
//             receive buffer without CPU help.  Each poll forces the device
//             ready, asks for the rx buffer usage (GETBUFFERUSAGE), then
//             reads exactly that many bytes from the data half and hands
//             each one to an on-chip consumer over a valid/ready stream.
//             When nothing is pending, or the status word is bad, it idles
//             POLLCYCLES cycles before polling again.
//  Ports    : clk_i/rst_i      clock, synchronous active-high reset
//             en_i             polling enable, looked at only in IDLE
//             wb_*             Wishbone initiator, one outstanding op,
//                              all request outputs registered
//             rx_stb_o/rx_dat_o/rx_rdy_i  byte stream to the consumer
//             err_o            one-cycle pulse on a bad GETBUF status
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_poller #(
  parameter  int ARCHBITSZ  = 16,
  parameter  int BASEADDR   = 0,
  parameter  int POLLCYCLES = 1000,
  localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [ADDRBITSZ-1:0]   wb_addr_o,
  output logic [ARCHBITSZ/8-1:0] wb_sel_o,
  output logic [ARCHBITSZ-1:0]   wb_dat_o,
  input  logic                   wb_bsy_i,
  input  logic                   wb_ack_i,
  input  logic [ARCHBITSZ-1:0]   wb_dat_i,
  output logic                   rx_stb_o,
  output logic [7:0]             rx_dat_o,
  input  logic                   rx_rdy_i,
  output logic                   err_o
);

  localparam int UW   = ARCHBITSZ - 2;
  localparam int CW   = $clog2(POLLCYCLES + 1);
  localparam int SELW = ARCHBITSZ / 8;

  // The command half sits 8 bytes above the data half.
  localparam logic [ADDRBITSZ-1:0] CMD_ADDR = ADDRBITSZ'(BASEADDR + 64/ARCHBITSZ);
  localparam logic [ADDRBITSZ-1:0] DAT_ADDR = ADDRBITSZ'(BASEADDR);

  // Command word = {arg, cmd[1:0]}; GETBUF with arg bit0=0 selects rx usage.
  localparam logic [ARCHBITSZ-1:0] CMD_DEVRDY    = '0;
  localparam logic [ARCHBITSZ-1:0] CMD_GETBUF_RX = ARCHBITSZ'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RDY0_W = 3'd1,
    S_GBUF_W = 3'd2,
    S_GBUF_R = 3'd3,
    S_RDY1_W = 3'd4,
    S_DAT_R  = 3'd5,
    S_OUT    = 3'd6,
    S_WAIT   = 3'd7
  } state_t;

  state_t                 state_q;
  logic                   cyc_q;
  logic                   stb_q;
  logic                   we_q;
  logic [ADDRBITSZ-1:0]   addr_q;
  logic [ARCHBITSZ-1:0]   dat_q;
  logic                   rx_stb_q;
  logic [7:0]             rx_dat_q;
  logic                   err_q;
  logic [UW-1:0]          usage_q;
  logic [CW-1:0]          cnt_q;

  // An ack only completes the op once the request has been (or is being)
  // accepted; an ack with cyc low is a leftover and is ignored.
  logic w_done;
  assign w_done = cyc_q && wb_ack_i && (!stb_q || !wb_bsy_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      rx_stb_q <= 1'b0;
      rx_dat_q <= '0;
      err_q    <= 1'b0;
      usage_q  <= '0;
      cnt_q    <= '0;
    end else begin
      err_q <= 1'b0;

      // Generic bus handshake; a new op issued below overrides these drops
      // in the same edge so back-to-back ops lose no cycle.
      if (stb_q && !wb_bsy_i) begin
        stb_q <= 1'b0;
      end
      if (w_done) begin
        cyc_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (en_i) begin
            state_q <= S_RDY0_W;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= CMD_ADDR;
            dat_q   <= CMD_DEVRDY;
          end
        end

        S_RDY0_W: begin
          if (w_done) begin
            state_q <= S_GBUF_W;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= CMD_ADDR;
            dat_q   <= CMD_GETBUF_RX;
          end
        end

        S_GBUF_W: begin
          if (w_done) begin
            state_q <= S_GBUF_R;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= CMD_ADDR;
            dat_q   <= '0;
          end
        end

        S_GBUF_R: begin
          if (w_done) begin
            // Status code 1 means the upper bits carry the usage count.
            if (wb_dat_i[1:0] == 2'd1) begin
              usage_q <= wb_dat_i[ARCHBITSZ-1:2];
            end else begin
              usage_q <= '0;
              err_q   <= 1'b1;
            end
            // The device needs a fresh DEVRDY before data reads.
            state_q <= S_RDY1_W;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= CMD_ADDR;
            dat_q   <= CMD_DEVRDY;
          end
        end

        S_RDY1_W: begin
          if (w_done) begin
            if (usage_q == '0) begin
              // The IDLE cycle is part of the back-off, so WAIT itself
              // lasts one cycle less than POLLCYCLES.
              cnt_q <= '0;
              if (POLLCYCLES == 1) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              state_q <= S_DAT_R;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= DAT_ADDR;
              dat_q   <= '0;
            end
          end
        end

        S_DAT_R: begin
          if (w_done) begin
            rx_dat_q <= wb_dat_i[7:0];
            rx_stb_q <= 1'b1;
            state_q  <= S_OUT;
          end
        end

        S_OUT: begin
          if (rx_rdy_i) begin
            rx_stb_q <= 1'b0;
            usage_q  <= (usage_q != '0) ? usage_q - UW'(1) : '0;
            if (usage_q != UW'(1)) begin
              state_q <= S_DAT_R;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= DAT_ADDR;
              dat_q   <= '0;
            end else begin
              // Buffer drained: repoll straight away.
              state_q <= S_IDLE;
            end
          end
        end

        S_WAIT: begin
          if (int'(cnt_q) >= POLLCYCLES - 2) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = {SELW{stb_q}};
  assign rx_stb_o  = rx_stb_q;
  assign rx_dat_o  = rx_dat_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire
